// File: rtl/ws2812_tx.sv
// Purpose: WS2812 single-wire NRZ transmitter; one colour bit per TBIT cycles, latch gap after each frame.
// Latency: bit_in sampled T0H-1 cycles into each bit; led_dout and done are registered outputs.
// Backpressure: none; the transmitter never stalls, the producer must present bit_in in time.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset (line returns to idle immediately)
//   bit_in   - colour bit to send, sampled at the edge ending cycle T0H-1 of each bit
//   done     - one-cycle pulse in the last cycle of each bit; producer advances on it
//   led_dout - serial waveform to the strip
//
// Build option: define WS2812_DOUT_INVERT_EN to drive an inverted waveform
// (idle/latch/reset level 1) for an inverting level shifter.
module ws2812_tx #(
  parameter int unsigned T0H          = 20,
  parameter int unsigned T1H          = 40,
  parameter int unsigned TBIT         = 63,
  parameter int unsigned RESET_CYCLES = 3000,
  parameter int unsigned FRAME_BITS   = 3072
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  output logic done,
  output logic led_dout
);

  localparam int unsigned BCW = $clog2(FRAME_BITS + 1);

  localparam logic [15:0]    C_T0H_M1  = 16'(T0H - 1);
  localparam logic [15:0]    C_T1H_M1  = 16'(T1H - 1);
  localparam logic [15:0]    C_TBIT_M1 = 16'(TBIT - 1);
  localparam logic [15:0]    C_RST_M1  = 16'(RESET_CYCLES - 1);
  localparam logic [BCW-1:0] C_FRAME   = BCW'(FRAME_BITS);

`ifdef WS2812_DOUT_INVERT_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_LATCH,
    S_HIGH,
    S_DATA,
    S_LOW
  } state_t;

  state_t         state, state_n;
  logic [15:0]    cnt, cnt_n;     // cycle index within the bit (or within the latch gap)
  logic [BCW-1:0] bcnt, bcnt_n;   // bits already sent in this frame
  logic [BCW-1:0] bcnt_inc;
  logic           bit_q, bit_n;   // bit captured for the DATA window
  logic           lvl_n;          // true-polarity line level for the next cycle
  logic           led_n;
  logic           done_n;

  assign bcnt_inc = bcnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LATCH;
      cnt      <= '0;
      bcnt     <= '0;
      bit_q    <= 1'b0;
      led_dout <= IDLE_LVL;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bcnt     <= bcnt_n;
      bit_q    <= bit_n;
      led_dout <= led_n;
      done     <= done_n;
    end
  end

  // The cycle counter runs continuously through HIGH/DATA/LOW, so the
  // phase boundaries are simple equality compares on one counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    bcnt_n  = bcnt;
    bit_n   = bit_q;

    case (state)
      S_LATCH: begin
        if (cnt == C_RST_M1) begin
          state_n = S_HIGH;
          cnt_n   = '0;
          bcnt_n  = '0;
        end
      end
      S_HIGH: begin
        if (cnt == C_T0H_M1) begin
          state_n = S_DATA;
          bit_n   = bit_in;
        end
      end
      S_DATA: begin
        if (cnt == C_T1H_M1) begin
          state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt == C_TBIT_M1) begin
          cnt_n = '0;
          if (bcnt_inc == C_FRAME) begin
            state_n = S_LATCH;
            bcnt_n  = '0;
          end else begin
            state_n = S_HIGH;
            bcnt_n  = bcnt_inc;
          end
        end
      end
      default: begin
        state_n = S_LATCH;
        cnt_n   = '0;
        bcnt_n  = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view, so the registered
  // value always matches the phase of the cycle it is driven in.
  always_comb begin
    lvl_n = 1'b0;
    case (state_n)
      S_HIGH:  lvl_n = 1'b1;
      S_DATA:  lvl_n = bit_n;
      default: lvl_n = 1'b0;
    endcase
    led_n  = lvl_n ^ IDLE_LVL;
    done_n = (state_n == S_LOW) && (cnt_n == C_TBIT_M1);
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Purpose: self-checking bench for ws2812_tx; scoreboard of driven bits vs measured high times.
// Latency: measures latch length, bit period, done position and frame gap on the line.
// Backpressure: none; bench supplies the next bit right after each done pulse.
module tb_ws2812_tx;

  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int TBIT = 63;
  localparam int RSTC = 3000;
  localparam int FB   = 16;
  localparam int NPAT = 5 * FB;

`ifdef WS2812_DOUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic bit_in;
  logic done;
  logic led_dout;

  int checks   = 0;
  int failures = 0;

  // monitor / scoreboard state
  bit   mon_en     = 1'b0;
  bit   first_rise = 1'b1;
  logic line_prev  = 1'b0;
  int   pos        = 0;
  int   hi         = 0;
  int   done_cnt   = 0;
  bit   exp_q[$];
  bit   pat[NPAT];

  ws2812_tx #(
    .T0H          (T0H),
    .T1H          (T1H),
    .TBIT         (TBIT),
    .RESET_CYCLES (RSTC),
    .FRAME_BITS   (FB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .done     (done),
    .led_dout (led_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic start_run();
    exp_q.delete();
    done_cnt   = 0;
    pos        = 0;
    hi         = 0;
    first_rise = 1'b1;
    line_prev  = 1'b0;
    bit_in     = pat[0];
    exp_q.push_back(pat[0]);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int c = 0; c < budget && done_cnt < target; c++) @(posedge clk);
    chk_eq("done_count", done_cnt, target);
  endtask

  // Monitor + driver: samples on the falling edge, measures each bit from
  // its rising edge, scores high time against the queued bit, and supplies
  // the next bit right after each done pulse.
  initial begin : monitor
    logic line;
    bit   e;
    bit   nxt;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        line = led_dout ^ INV;
        if (line && !line_prev) begin
          if (first_rise)
            chk_eq("latch_after_reset", pos, RSTC);
          else if (done_cnt % FB == 0)
            chk_eq("frame_gap", pos, TBIT + RSTC);
          else
            chk_eq("bit_period", pos, TBIT);
          first_rise = 1'b0;
          pos        = 0;
          hi         = 0;
        end
        if (line) hi++;
        if (done) begin
          chk_eq("done_pos", pos, TBIT - 1);
          if (exp_q.size() == 0) begin
            chk_eq("scoreboard_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk_eq(e ? "high_time_1" : "high_time_0", hi, e ? T1H : T0H);
          end
          done_cnt++;
          nxt    = pat[done_cnt % NPAT];
          bit_in = nxt;
          exp_q.push_back(nxt);
        end else if (!first_rise && pos == T0H + 5) begin
          // change bit_in after the sample edge: must only affect the next bit
          bit_in = pat[(done_cnt + 1) % NPAT];
        end else if (!first_rise && pos > T0H + 5 && pos < TBIT - 1) begin
          bit_in = 1'($urandom_range(0, 1));
        end
        line_prev = line;
        pos++;
      end
    end
  end

  initial begin : main
    // frame 0 alternating 1/0, frame 1 all ones, frame 2 all zeros, rest random
    for (int i = 0; i < NPAT; i++) begin
      case (i / FB)
        0:       pat[i] = (i % 2 == 0);
        1:       pat[i] = 1'b1;
        2:       pat[i] = 1'b0;
        default: pat[i] = 1'($urandom_range(0, 1));
      endcase
    end

    rst_n  = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_led", int'(led_dout), int'(INV));
    chk_eq("reset_done", int'(done), 0);

    start_run();
    wait_done(4 * FB, 4 * (FB * TBIT + RSTC) + 500);

    // wait into the first bit of the next frame, then reset mid-high
    for (int c = 0; c < RSTC + 200 && !(led_dout ^ INV); c++) @(posedge clk);
    chk_eq("line_high_before_reset", int'(led_dout ^ INV), 1);
    repeat (5) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_eq("async_reset_led", int'(led_dout), int'(INV));
    chk_eq("async_reset_done", int'(done), 0);
    repeat (4) @(negedge clk);
    chk_eq("held_reset_led", int'(led_dout), int'(INV));

    // restart: full latch, one frame, and the first bit after its gap
    start_run();
    wait_done(FB + 1, 2 * (FB * TBIT + RSTC) + 500);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
